seq_status_tracker: RTL and testbench
=====================================

Name: seq_status_tracker

Overview:
Downstream consumer of the SEQ core's per-instruction outputs. Samples the retired PC, opcode and error flags each time an instruction completes. Maintains the architectural status (AOK/HLT/ADR/INS) as a sticky state machine and counts cycles and retired instructions. Keeps a circular trace buffer of the last TRACE_DEPTH retired PCs, read out through a pop handshake for post-mortem debug.

Parameters:
TRACE_DEPTH  8   trace buffer entries; power of 2, minimum 2
CNT_W  32  width of cycle_count and retired_count
WDOG_CYCLES  64  idle-cycle limit for the optional watchdog

Ports:
clk  in  1  core clock, rising-edge active
rst  in  1  synchronous active-high reset
retire_valid  in  1  one-cycle pulse: the instruction at PC_adress has completed
PC_adress  in  64  PC of the retiring instruction
Ins_Code  in  4  icode of the retiring instruction
Ins_fun  in  4  ifun of the retiring instruction
imemory_error  in  1  instruction fetch address error
data_memory_error  in  1  data memory address error
instruction_invalid_check  in  1  invalid icode/ifun
stat  out  3  Y86 status code: 1=AOK, 2=HLT, 3=ADR, 4=INS
AOK, HLT, ADR, INS  out  1 each  one-hot decode of stat
halt_req  out  1  high in any terminal state; the core stops PC update
fault_PC  out  64  PC of the instruction that ended execution
retired_count  out  CNT_W  AOK instructions retired
cycle_count  out  CNT_W  cycles spent in RUN
trace_rd_en  in  1  pop the oldest trace entry
trace_rd_data  out  64  popped PC
trace_rd_valid  out  1  trace_rd_data valid; one-cycle pulse
trace_count  out  $clog2(TRACE_DEPTH)+1  current number of entries
trace_ovf  out  1  sticky: at least one entry was overwritten

Behaviour:
- Reset: rst is sampled on the rising edge of clk.
  - State goes to IDLE; stat=1, AOK=1, all other flags 0.
  - halt_req=0, fault_PC=0, both counters 0.
  - trace_count=0, trace_ovf=0, trace_rd_valid=0, trace_rd_data=0; read and write pointers 0.
- States: IDLE, RUN, HALTED, FAULT_ADR, FAULT_INS.
- IDLE -> RUN on the first retire_valid. That retire is also classified by the same rules as in RUN.
- RUN: cycle_count increments every cycle, saturating at all-ones.
- Retire classification, evaluated on retire_valid, priority order:
  1. imemory_error or data_memory_error -> FAULT_ADR, stat=3.
  2. else instruction_invalid_check -> FAULT_INS, stat=4.
  3. else Ins_Code==0 -> HALTED, stat=2.
  4. else stay in RUN; retired_count increments, saturating.
- Entering any terminal state: fault_PC<=PC_adress and halt_req=1, both on the same edge. retired_count is not incremented.
- Terminal states persist until rst. Later retire_valid pulses are ignored; counters and trace freeze.
- Error flags are ignored while retire_valid=0.
- stat and the one-hot flags are registered: they update on the edge that samples the retire, i.e. 1-cycle latency.
- Trace write: every classified retire, including the terminating one, writes PC_adress at wr_ptr; wr_ptr increments modulo TRACE_DEPTH.
  - Full on write: overwrite the oldest entry, advance rd_ptr, set trace_ovf; trace_count stays at TRACE_DEPTH.
- Trace read: trace_rd_en with trace_count>0 gives the oldest entry on trace_rd_data with trace_rd_valid=1 on the next cycle, then rd_ptr increments.
  - trace_rd_en while empty: ignored, trace_rd_valid stays 0.
  - Reads are allowed in every state, including terminal states.
- Simultaneous write and read:
  - Not full: the read returns the oldest entry and trace_count is unchanged.
  - Full: the read returns the oldest entry before the write, the write overwrites that freed slot, trace_count stays TRACE_DEPTH, trace_ovf is not set.
  - Empty: the write occurs, the read is ignored, trace_count becomes 1.
- rst mid-run or in a terminal state: full return to the reset values above. Trace contents are invalidated via pointers and count.

Optional Feature:
STAT_WATCHDOG_EN.
- Defined: an idle counter runs in RUN, clears on each retire_valid, and adds output wdog_fire (1 bit, reset 0).
  - At WDOG_CYCLES consecutive cycles without a retire: go to FAULT_ADR, stat=3, wdog_fire=1 (sticky), halt_req=1, fault_PC=last retired PC.
  - If a retire arrives on the limit cycle, the retire wins.
- Undefined: no counter, no wdog_fire port; RUN can be left only by a retire.

Test Plan:
- rst, then retires at PC 0,10,20 (icode 3, no errors), then PC 30 icode 0 -> stat=2, HLT=1, halt_req=1, fault_PC=30, retired_count=3; pops return 0,10,20,30.
- Retire PC 0x40 with data_memory_error=1 and instruction_invalid_check=1 -> stat=3 (ADR wins), fault_PC=0x40; a following retire at 0x50 is ignored, trace_count=1.
- 10 AOK retires at PCs 0..9 with TRACE_DEPTH=8 -> trace_count=8, trace_ovf=1; pops return 2..9, then trace_rd_en while empty gives trace_rd_valid=0.
- Trace full with oldest=2, simultaneous retire PC 100 and pop -> returns 2, trace_count=8, trace_ovf unchanged; remaining order 3..9,100.
- Assert rst in FAULT_INS with 5 entries -> next cycle stat=1, counters 0, trace_count=0, halt_req=0.
- STAT_WATCHDOG_EN, WDOG_CYCLES=64: retire at PC 8 then 64 idle cycles -> stat=3, wdog_fire=1, fault_PC=8; retire on cycle 64 instead -> stays RUN.

Source files
------------

// File: rtl/seq_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : seq_status_tracker
// Purpose  : Tracks retirement of SEQ core instructions. Holds a sticky
//            architectural status (AOK/HLT/ADR/INS), counts RUN cycles and
//            retired AOK instructions, and keeps a circular trace buffer of
//            the most recent retired PCs that can be popped for debug.
// Optional : STAT_WATCHDOG_EN - idle-cycle watchdog that forces FAULT_ADR
//            after WDOG_CYCLES cycles in RUN without a retire; adds wdog_fire.
// Ports    :
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   retire_valid                one-cycle pulse per completed instruction
//   PC_adress, Ins_Code, Ins_fun  PC / icode / ifun of the retiring instruction
//   imemory_error, data_memory_error, instruction_invalid_check  error flags
//   stat, AOK, HLT, ADR, INS    registered status code and its one-hot decode
//   halt_req, fault_PC          terminal-state indication and ending PC
//   retired_count, cycle_count  saturating counters
//   trace_rd_en/_data/_valid    trace pop handshake
//   trace_count, trace_ovf      trace occupancy and sticky overwrite flag
//   wdog_fire                   (STAT_WATCHDOG_EN only) sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module seq_status_tracker #(
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           retire_valid,
    input  logic [63:0]                    PC_adress,
    input  logic [3:0]                     Ins_Code,
    input  logic [3:0]                     Ins_fun,
    input  logic                           imemory_error,
    input  logic                           data_memory_error,
    input  logic                           instruction_invalid_check,
    output logic [2:0]                     stat,
    output logic                           AOK,
    output logic                           HLT,
    output logic                           ADR,
    output logic                           INS,
    output logic                           halt_req,
    output logic [63:0]                    fault_PC,
    output logic [CNT_W-1:0]               retired_count,
    output logic [CNT_W-1:0]               cycle_count,
`ifdef STAT_WATCHDOG_EN
    output logic                           wdog_fire,
`endif
    input  logic                           trace_rd_en,
    output logic [63:0]                    trace_rd_data,
    output logic                           trace_rd_valid,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_ovf
);

    localparam int c_PTR_W  = $clog2(TRACE_DEPTH);
    localparam int c_TCNT_W = c_PTR_W + 1;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_RUN       = 3'd1;
    localparam logic [2:0] c_ST_HALTED    = 3'd2;
    localparam logic [2:0] c_ST_FAULT_ADR = 3'd3;
    localparam logic [2:0] c_ST_FAULT_INS = 3'd4;

    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    localparam logic [CNT_W-1:0]    c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_TCNT_W-1:0] c_TCNT_ONE  = {{(c_TCNT_W-1){1'b0}}, 1'b1};
    localparam logic [c_TCNT_W-1:0] c_TCNT_FULL = c_TCNT_W'(TRACE_DEPTH);

    logic [2:0]          r_state_q,     w_state_d;
    logic [2:0]          r_stat_q,      w_stat_d;
    logic                r_halt_q,      w_halt_d;
    logic [63:0]         r_fault_pc_q,  w_fault_pc_d;
    logic [CNT_W-1:0]    r_retired_q,   w_retired_d;
    logic [CNT_W-1:0]    r_cycle_q,     w_cycle_d;
    logic [c_PTR_W-1:0]  r_wr_ptr_q,    w_wr_ptr_d;
    logic [c_PTR_W-1:0]  r_rd_ptr_q,    w_rd_ptr_d;
    logic [c_TCNT_W-1:0] r_tcount_q,    w_tcount_d;
    logic                r_ovf_q,       w_ovf_d;
    logic                r_rd_valid_q,  w_rd_valid_d;
    logic [63:0]         r_rd_data_q,   w_rd_data_d;
    logic [63:0]         r_mem [TRACE_DEPTH];

    logic w_active;
    logic w_accept;
    logic w_rd;
    logic w_full;
    logic w_mem_we;

`ifdef STAT_WATCHDOG_EN
    localparam int                 c_IDLE_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = {{(c_IDLE_W-1){1'b0}}, 1'b1};
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(WDOG_CYCLES - 1);

    logic [c_IDLE_W-1:0] r_idle_q,    w_idle_d;
    logic [63:0]         r_last_pc_q, w_last_pc_d;
    logic                r_wdog_q,    w_wdog_d;
`endif

    // ifun does not influence status; it is part of the retire bundle only.
    logic w_unused;
    assign w_unused = ^{Ins_fun, (WDOG_CYCLES < 1)};

    always_comb begin
        w_state_d    = r_state_q;
        w_stat_d     = r_stat_q;
        w_halt_d     = r_halt_q;
        w_fault_pc_d = r_fault_pc_q;
        w_retired_d  = r_retired_q;
        w_cycle_d    = r_cycle_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_tcount_d   = r_tcount_q;
        w_ovf_d      = r_ovf_q;
        w_rd_valid_d = 1'b0;
        w_rd_data_d  = r_rd_data_q;
`ifdef STAT_WATCHDOG_EN
        w_idle_d     = r_idle_q;
        w_last_pc_d  = r_last_pc_q;
        w_wdog_d     = r_wdog_q;
`endif

        // Only IDLE and RUN accept retires; terminal states freeze everything
        // except trace reads.
        w_active = (r_state_q == c_ST_IDLE) || (r_state_q == c_ST_RUN);
        w_accept = retire_valid && w_active;
        w_rd     = trace_rd_en && (r_tcount_q != '0);
        w_full   = (r_tcount_q == c_TCNT_FULL);
        w_mem_we = w_accept;

        if ((r_state_q == c_ST_RUN) && (r_cycle_q != c_CNT_MAX)) begin
            w_cycle_d = r_cycle_q + c_CNT_ONE;
        end

        if (w_accept) begin
            w_state_d = c_ST_RUN;
            if (imemory_error || data_memory_error) begin
                w_state_d    = c_ST_FAULT_ADR;
                w_stat_d     = c_STAT_ADR;
                w_halt_d     = 1'b1;
                w_fault_pc_d = PC_adress;
            end else if (instruction_invalid_check) begin
                w_state_d    = c_ST_FAULT_INS;
                w_stat_d     = c_STAT_INS;
                w_halt_d     = 1'b1;
                w_fault_pc_d = PC_adress;
            end else if (Ins_Code == 4'd0) begin
                w_state_d    = c_ST_HALTED;
                w_stat_d     = c_STAT_HLT;
                w_halt_d     = 1'b1;
                w_fault_pc_d = PC_adress;
            end else if (r_retired_q != c_CNT_MAX) begin
                w_retired_d = r_retired_q + c_CNT_ONE;
            end
        end

`ifdef STAT_WATCHDOG_EN
        if (w_accept) begin
            w_last_pc_d = PC_adress;
        end
        // A retire on the limit cycle clears the idle count and so wins.
        if (r_state_q == c_ST_RUN) begin
            if (retire_valid) begin
                w_idle_d = '0;
            end else if (r_idle_q == c_IDLE_LAST) begin
                w_state_d    = c_ST_FAULT_ADR;
                w_stat_d     = c_STAT_ADR;
                w_halt_d     = 1'b1;
                w_fault_pc_d = r_last_pc_q;
                w_wdog_d     = 1'b1;
            end else begin
                w_idle_d = r_idle_q + c_IDLE_ONE;
            end
        end
`endif

        // Trace read always takes the oldest entry as it stood before any
        // same-cycle write, so a full buffer with read+write simply rotates.
        if (w_rd) begin
            w_rd_valid_d = 1'b1;
            w_rd_data_d  = r_mem[r_rd_ptr_q];
            w_rd_ptr_d   = r_rd_ptr_q + c_PTR_ONE;
        end

        if (w_accept) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            if (w_full && !w_rd) begin
                // Overwrite the oldest entry: drop it by advancing rd_ptr.
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
                w_ovf_d    = 1'b1;
            end
        end

        case ({w_accept, w_rd})
            2'b10:   w_tcount_d = w_full ? r_tcount_q : (r_tcount_q + c_TCNT_ONE);
            2'b01:   w_tcount_d = r_tcount_q - c_TCNT_ONE;
            default: w_tcount_d = r_tcount_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_ST_IDLE;
            r_stat_q     <= c_STAT_AOK;
            r_halt_q     <= 1'b0;
            r_fault_pc_q <= '0;
            r_retired_q  <= '0;
            r_cycle_q    <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_tcount_q   <= '0;
            r_ovf_q      <= 1'b0;
            r_rd_valid_q <= 1'b0;
            r_rd_data_q  <= '0;
`ifdef STAT_WATCHDOG_EN
            r_idle_q     <= '0;
            r_last_pc_q  <= '0;
            r_wdog_q     <= 1'b0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_stat_q     <= w_stat_d;
            r_halt_q     <= w_halt_d;
            r_fault_pc_q <= w_fault_pc_d;
            r_retired_q  <= w_retired_d;
            r_cycle_q    <= w_cycle_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_tcount_q   <= w_tcount_d;
            r_ovf_q      <= w_ovf_d;
            r_rd_valid_q <= w_rd_valid_d;
            r_rd_data_q  <= w_rd_data_d;
`ifdef STAT_WATCHDOG_EN
            r_idle_q     <= w_idle_d;
            r_last_pc_q  <= w_last_pc_d;
            r_wdog_q     <= w_wdog_d;
`endif
        end
    end

    // Trace storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[r_wr_ptr_q] <= PC_adress;
        end
    end

    assign stat           = r_stat_q;
    assign AOK            = (r_stat_q == c_STAT_AOK);
    assign HLT            = (r_stat_q == c_STAT_HLT);
    assign ADR            = (r_stat_q == c_STAT_ADR);
    assign INS            = (r_stat_q == c_STAT_INS);
    assign halt_req       = r_halt_q;
    assign fault_PC       = r_fault_pc_q;
    assign retired_count  = r_retired_q;
    assign cycle_count    = r_cycle_q;
    assign trace_rd_data  = r_rd_data_q;
    assign trace_rd_valid = r_rd_valid_q;
    assign trace_count    = r_tcount_q;
    assign trace_ovf      = r_ovf_q;
`ifdef STAT_WATCHDOG_EN
    assign wdog_fire      = r_wdog_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_status_tracker
// Purpose  : Self-checking bench for seq_status_tracker. A queue-based
//            reference model predicts every output each cycle; directed
//            sequences exercise the documented scenarios, followed by
//            randomized retire/pop traffic with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_status_tracker;

    localparam int D     = 8;
    localparam int CW    = 32;
    localparam int WD    = 64;
    localparam int TCW   = $clog2(D) + 1;
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            retire_valid = 1'b0;
    logic [63:0]     PC_adress = '0;
    logic [3:0]      Ins_Code = '0;
    logic [3:0]      Ins_fun = '0;
    logic            imemory_error = 1'b0;
    logic            data_memory_error = 1'b0;
    logic            instruction_invalid_check = 1'b0;
    logic [2:0]      stat;
    logic            AOK, HLT, ADR, INS;
    logic            halt_req;
    logic [63:0]     fault_PC;
    logic [CW-1:0]   retired_count;
    logic [CW-1:0]   cycle_count;
    logic            trace_rd_en = 1'b0;
    logic [63:0]     trace_rd_data;
    logic            trace_rd_valid;
    logic [TCW-1:0]  trace_count;
    logic            trace_ovf;
`ifdef STAT_WATCHDOG_EN
    logic            wdog_fire;
`endif

    seq_status_tracker #(
        .TRACE_DEPTH (D),
        .CNT_W       (CW),
        .WDOG_CYCLES (WD)
    ) u_dut (
        .clk                       (clk),
        .rst                       (rst),
        .retire_valid              (retire_valid),
        .PC_adress                 (PC_adress),
        .Ins_Code                  (Ins_Code),
        .Ins_fun                   (Ins_fun),
        .imemory_error             (imemory_error),
        .data_memory_error         (data_memory_error),
        .instruction_invalid_check (instruction_invalid_check),
        .stat                      (stat),
        .AOK                       (AOK),
        .HLT                       (HLT),
        .ADR                       (ADR),
        .INS                       (INS),
        .halt_req                  (halt_req),
        .fault_PC                  (fault_PC),
        .retired_count             (retired_count),
        .cycle_count               (cycle_count),
`ifdef STAT_WATCHDOG_EN
        .wdog_fire                 (wdog_fire),
`endif
        .trace_rd_en               (trace_rd_en),
        .trace_rd_data             (trace_rd_data),
        .trace_rd_valid            (trace_rd_valid),
        .trace_count               (trace_count),
        .trace_ovf                 (trace_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_q[$];
    int          m_stat;
    bit          m_started;
    bit          m_halt;
    bit          m_ovf;
    bit          m_rd_valid;
    bit          m_wdog;
    logic [63:0] m_fault;
    logic [63:0] m_rd_data;
    logic [63:0] m_last;
    longint      m_ret;
    longint      m_cyc;
    int          m_idle;

    function automatic void model_reset();
        m_q.delete();
        m_stat = 1; m_started = 0; m_halt = 0; m_ovf = 0; m_rd_valid = 0;
        m_wdog = 0; m_fault = '0; m_rd_data = '0; m_last = '0;
        m_ret = 0; m_cyc = 0; m_idle = 0;
    endfunction

    function automatic void terminate(int code, logic [63:0] pc);
        m_stat  = code;
        m_halt  = 1;
        m_fault = pc;
    endfunction

    function automatic void model_step();
        bit running;
        if (rst) begin
            model_reset();
            return;
        end
        running = (m_stat == 1);
        if (running && m_started && m_cyc < CMAX) m_cyc++;
        m_rd_valid = 0;
        if (trace_rd_en && m_q.size() > 0) begin
            m_rd_data  = m_q.pop_front();
            m_rd_valid = 1;
        end
        if (running && retire_valid) begin
            m_q.push_back(PC_adress);
            if (m_q.size() > D) begin
                void'(m_q.pop_front());
                m_ovf = 1;
            end
            m_started = 1;
            m_last    = PC_adress;
            m_idle    = 0;
            if (imemory_error || data_memory_error) terminate(3, PC_adress);
            else if (instruction_invalid_check)     terminate(4, PC_adress);
            else if (Ins_Code == 0)                 terminate(2, PC_adress);
            else if (m_ret < CMAX)                  m_ret++;
        end
`ifdef STAT_WATCHDOG_EN
        else if (running && m_started) begin
            m_idle++;
            if (m_idle == WD) begin
                terminate(3, m_last);
                m_wdog = 1;
            end
        end
`endif
    endfunction

    task automatic compare_all();
        chk("stat",     64'(stat),          64'(m_stat));
        chk("AOK",      64'(AOK),           64'(m_stat == 1));
        chk("HLT",      64'(HLT),           64'(m_stat == 2));
        chk("ADR",      64'(ADR),           64'(m_stat == 3));
        chk("INS",      64'(INS),           64'(m_stat == 4));
        chk("halt_req", 64'(halt_req),      64'(m_halt));
        chk("fault_PC", fault_PC,           m_fault);
        chk("retired",  64'(retired_count), 64'(m_ret));
        chk("cycles",   64'(cycle_count),   64'(m_cyc));
        chk("tcount",   64'(trace_count),   64'(m_q.size()));
        chk("tovf",     64'(trace_ovf),     64'(m_ovf));
        chk("rd_valid", 64'(trace_rd_valid), 64'(m_rd_valid));
        if (m_rd_valid) chk("rd_data", trace_rd_data, m_rd_data);
`ifdef STAT_WATCHDOG_EN
        chk("wdog", 64'(wdog_fire), 64'(m_wdog));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit rv, input logic [63:0] pc, input logic [3:0] ic,
                         input bit im, input bit dm, input bit inv, input bit rd);
        retire_valid = rv; PC_adress = pc; Ins_Code = ic; Ins_fun = 4'h0;
        imemory_error = im; data_memory_error = dm; instruction_invalid_check = inv;
        trace_rd_en = rd;
        tick();
        retire_valid = 0; imemory_error = 0; data_memory_error = 0;
        instruction_invalid_check = 0; trace_rd_en = 0;
    endtask

    task automatic reset_dut();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 4'h0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;

        // Scenario 1: three AOK retires, then halt; drain the trace.
        reset_dut();
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_AOK", 64'(AOK), 64'd1);
        chk("rst_rd_data", trace_rd_data, 64'd0);
        chk("rst_tcount", 64'(trace_count), 64'd0);
        drive(1, 64'd0,  4'h3, 0, 0, 0, 0);
        drive(1, 64'd10, 4'h3, 0, 0, 0, 0);
        drive(1, 64'd20, 4'h3, 0, 0, 0, 0);
        drive(1, 64'd30, 4'h0, 0, 0, 0, 0);
        chk("s1_stat", 64'(stat), 64'd2);
        chk("s1_HLT", 64'(HLT), 64'd1);
        chk("s1_halt_req", 64'(halt_req), 64'd1);
        chk("s1_fault_PC", fault_PC, 64'd30);
        chk("s1_retired", 64'(retired_count), 64'd3);
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 4'h0, 0, 0, 0, 1);
            chk("s1_pop", trace_rd_data, 64'(i * 10));
        end

        // Scenario 2: ADR wins over INS; later retires ignored.
        reset_dut();
        drive(1, 64'h40, 4'h3, 0, 1, 1, 0);
        chk("s2_stat", 64'(stat), 64'd3);
        chk("s2_fault_PC", fault_PC, 64'h40);
        drive(1, 64'h50, 4'h3, 0, 0, 0, 0);
        chk("s2_tcount", 64'(trace_count), 64'd1);

        // Scenario 3: overflow, drain, pop while empty.
        reset_dut();
        for (int i = 0; i < 10; i++) drive(1, 64'(i), 4'h3, 0, 0, 0, 0);
        chk("s3_tcount", 64'(trace_count), 64'd8);
        chk("s3_ovf", 64'(trace_ovf), 64'd1);
        for (int i = 2; i < 10; i++) begin
            drive(0, '0, 4'h0, 0, 0, 0, 1);
            chk("s3_pop", trace_rd_data, 64'(i));
        end
        drive(0, '0, 4'h0, 0, 0, 0, 1);
        chk("s3_empty_pop", 64'(trace_rd_valid), 64'd0);

        // Scenario 4: simultaneous write and read with buffer full.
        reset_dut();
        for (int i = 0; i < 10; i++) drive(1, 64'(i), 4'h3, 0, 0, 0, 0);
        drive(1, 64'd100, 4'h3, 0, 0, 0, 1);
        chk("s4_pop", trace_rd_data, 64'd2);
        chk("s4_tcount", 64'(trace_count), 64'd8);
        chk("s4_ovf", 64'(trace_ovf), 64'd1);
        for (int i = 3; i <= 10; i++) begin
            drive(0, '0, 4'h0, 0, 0, 0, 1);
            chk("s4_rest", trace_rd_data, (i == 10) ? 64'd100 : 64'(i));
        end

        // Scenario 5: reset out of FAULT_INS with five entries.
        reset_dut();
        for (int i = 0; i < 4; i++) drive(1, 64'(16 + i), 4'h6, 0, 0, 0, 0);
        drive(1, 64'd99, 4'h6, 0, 0, 1, 0);
        chk("s5_stat", 64'(stat), 64'd4);
        chk("s5_tcount", 64'(trace_count), 64'd5);
        reset_dut();
        chk("s5_rst_stat", 64'(stat), 64'd1);
        chk("s5_rst_retired", 64'(retired_count), 64'd0);
        chk("s5_rst_cycles", 64'(cycle_count), 64'd0);
        chk("s5_rst_tcount", 64'(trace_count), 64'd0);
        chk("s5_rst_halt", 64'(halt_req), 64'd0);

`ifdef STAT_WATCHDOG_EN
        // Scenario 6: watchdog fires after WD idle cycles; a retire on the
        // limit cycle keeps the core in RUN.
        reset_dut();
        drive(1, 64'd8, 4'h3, 0, 0, 0, 0);
        idle_n(WD - 1);
        chk("s6_pre_stat", 64'(stat), 64'd1);
        idle_n(1);
        chk("s6_stat", 64'(stat), 64'd3);
        chk("s6_wdog", 64'(wdog_fire), 64'd1);
        chk("s6_fault_PC", fault_PC, 64'd8);
        reset_dut();
        drive(1, 64'd8, 4'h3, 0, 0, 0, 0);
        idle_n(WD - 1);
        drive(1, 64'd9, 4'h3, 0, 0, 0, 0);
        chk("s6b_stat", 64'(stat), 64'd1);
        chk("s6b_wdog", 64'(wdog_fire), 64'd0);
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int seg = 0; seg < 30; seg++) begin
            int len, rv_pct, rd_pct;
            reset_dut();
            len    = $urandom_range(150, 20);
            rv_pct = $urandom_range(80, 3);
            rd_pct = $urandom_range(60, 0);
            for (int c = 0; c < len; c++) begin
                rst          = ($urandom_range(199, 0) == 0);
                retire_valid = ($urandom_range(99, 0) < rv_pct);
                PC_adress    = {$urandom, $urandom};
                Ins_Code     = ($urandom_range(29, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
                Ins_fun      = 4'($urandom_range(15, 0));
                imemory_error             = ($urandom_range(59, 0) == 0);
                data_memory_error         = ($urandom_range(59, 0) == 0);
                instruction_invalid_check = ($urandom_range(39, 0) == 0);
                trace_rd_en  = ($urandom_range(99, 0) < rd_pct);
                tick();
            end
            rst = 0; retire_valid = 0; imemory_error = 0; data_memory_error = 0;
            instruction_invalid_check = 0; trace_rd_en = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
